pcie_block_dispatcher: RTL

- Host-side ingress bridge between the PCIe row stream and the NoC PE write port of the host-attached node (node 0).
- Accepts 256-bit rows over valid/ready; every 8 consecutive rows form one 8x8 DCT block.
- Each row is tagged with its row index (pck_no) and a destination PE, then emitted as one NoC flit.
- Whole blocks are dispatched round-robin to PE nodes 1..X*Y-1.

---
 rtl/pcie_block_dispatcher_pkg.sv | 35 +++
 rtl/pcie_block_dispatcher_dispatch_fifo.sv | 85 ++++++++
 rtl/pcie_block_dispatcher.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pcie_block_dispatcher_pkg.sv
// Shared types and constants for the PCIe block dispatcher: mesh geometry,
// flit layout, tagging FSM encoding and node-to-coordinate conversion.
package pcie_block_dispatcher_pkg;

   localparam int X              = 2;
   localparam int Y              = 2;
   localparam int DATA_WIDTH     = 256;
   localparam int PCK_NUM        = 3;

   // Coordinate fields keep at least one bit so a 1-wide mesh still has a field.
   localparam int X_SIZE         = (X > 1) ? $clog2(X) : 1;
   localparam int Y_SIZE         = (Y > 1) ? $clog2(Y) : 1;
   localparam int XY_SIZE        = X_SIZE + Y_SIZE;
   localparam int TOTAL_WIDTH    = X_SIZE + Y_SIZE + PCK_NUM + DATA_WIDTH;
   localparam int ROWS_PER_BLOCK = 2 ** PCK_NUM;
   localparam int NODES          = X * Y;
   localparam int NODE_W         = (NODES > 1) ? $clog2(NODES) : 1;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Node n sits at column n % X, row n / X; packed as {y, x}.
   function automatic logic [XY_SIZE-1:0] node_to_xy(input logic [NODE_W-1:0] node);
      int unsigned      n;
      logic [X_SIZE-1:0] x;
      logic [Y_SIZE-1:0] y;
      n = 32'(node);
      x = X_SIZE'(n % unsigned'(X));
      y = Y_SIZE'(n / unsigned'(X));
      return {y, x};
   endfunction

endpackage

// File: rtl/pcie_block_dispatcher_dispatch_fifo.sv
// Small synchronous FIFO with a registered head: o_dout only changes when a
// new head is loaded, so it holds its last value once the FIFO drains.
// Simultaneous push and pop while full is accepted.
module dispatch_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_dout;

   logic             w_do_push;
   logic             w_do_pop;
   logic [PW-1:0]    w_rd_next;
   logic [CW-1:0]    w_count_next;
   logic [WIDTH-1:0] w_dout_next;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == CW'(0));
   assign o_dout    = r_dout;
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign w_rd_next = r_rd_ptr + PW'(1);

   // Occupancy update from the push/pop pair.
   always_comb begin
      w_count_next = r_count;
      case ({w_do_push, w_do_pop})
         2'b10:   w_count_next = r_count + CW'(1);
         2'b01:   w_count_next = r_count - CW'(1);
         default: w_count_next = r_count;
      endcase
   end

   // Next head: the following entry on a pop, the incoming word when it lands in an empty slot.
   always_comb begin
      w_dout_next = r_dout;
      if (w_do_pop && (r_count > CW'(1))) begin
         w_dout_next = r_mem[w_rd_next];
      end else if (w_do_push && ((r_count == CW'(0)) || (w_do_pop && (r_count == CW'(1))))) begin
         w_dout_next = i_din;
      end else begin
         w_dout_next = r_dout;
      end
   end

   // Storage, pointers, occupancy and registered head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_dout   <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= w_rd_next;
         end
         r_count <= w_count_next;
         r_dout  <= w_dout_next;
      end
   end

endmodule

// File: rtl/pcie_block_dispatcher.sv
// Host ingress bridge: tags each 256-bit PCIe row with its row index and a
// per-block destination PE, buffers it and emits it as one NoC flit.
// Blocks of ROWS_PER_BLOCK rows go round-robin to nodes 1..X*Y-1.
// Optional build macro DISPATCH_STATS_EN adds o_blocks_sent / o_stall_cycles.
module pcie_block_dispatcher
   import pcie_block_dispatcher_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_valid,
   input  logic [DATA_WIDTH-1:0]  i_data,
   output logic                   o_ready,
   output logic                   w_valid_pe,
   output logic [TOTAL_WIDTH-1:0] w_data_pe,
   input  logic                   w_ready_pe,
`ifdef DISPATCH_STATS_EN
   output logic [31:0]            o_blocks_sent,
   output logic [31:0]            o_stall_cycles,
`endif
   output logic                   o_busy
);

   localparam logic [PCK_NUM-1:0] LAST_ROW   = PCK_NUM'(ROWS_PER_BLOCK - 1);
   localparam logic [NODE_W-1:0]  DEST_FIRST = NODE_W'((NODES > 1) ? 1 : 0);
   localparam logic [NODE_W-1:0]  DEST_LAST  = NODE_W'(NODES - 1);

   state_t               r_state;
   state_t               w_state_next;
   logic [PCK_NUM-1:0]   r_row_cnt;
   logic [PCK_NUM-1:0]   w_row_cnt_next;
   logic [NODE_W-1:0]    r_dest;
   logic [NODE_W-1:0]    w_dest_next;
   logic                 r_init;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic                 w_accept;
   logic [TOTAL_WIDTH-1:0] w_flit;

   assign w_valid_pe = !w_empty;
   assign w_pop      = w_valid_pe && w_ready_pe;
   // A pop in the same cycle frees the slot the incoming row needs.
   assign o_ready    = r_init && (!w_full || w_pop);
   assign w_accept   = i_valid && o_ready;
   assign o_busy     = (r_state == STREAM) || !w_empty;
   assign w_flit     = {i_data, r_row_cnt, node_to_xy(r_dest)};

   // Holds o_ready low until the first clock after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_init <= 1'b0;
      end else begin
         r_init <= 1'b1;
      end
   end

   // Tagging FSM, row counter and per-block destination registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_row_cnt <= '0;
         r_dest    <= DEST_FIRST;
      end else begin
         r_state   <= w_state_next;
         r_row_cnt <= w_row_cnt_next;
         r_dest    <= w_dest_next;
      end
   end

   // Next state: count rows, and on the last row of a block rotate the destination.
   always_comb begin
      w_state_next   = r_state;
      w_row_cnt_next = r_row_cnt;
      w_dest_next    = r_dest;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_next   = STREAM;
               w_row_cnt_next = PCK_NUM'(1);
            end else begin
               w_state_next   = IDLE;
            end
         end
         STREAM: begin
            if (w_accept) begin
               if (r_row_cnt == LAST_ROW) begin
                  w_state_next   = IDLE;
                  w_row_cnt_next = '0;
                  if (NODES == 1) begin
                     w_dest_next = '0;
                  end else if (r_dest == DEST_LAST) begin
                     w_dest_next = DEST_FIRST;
                  end else begin
                     w_dest_next = r_dest + NODE_W'(1);
                  end
               end else begin
                  w_row_cnt_next = r_row_cnt + PCK_NUM'(1);
               end
            end else begin
               w_state_next = STREAM;
            end
         end
         default: begin
            w_state_next   = IDLE;
            w_row_cnt_next = '0;
         end
      endcase
   end

   dispatch_fifo #(
      .WIDTH (TOTAL_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_accept),
      .i_din   (w_flit),
      .i_pop   (w_ready_pe),
      .o_dout  (w_data_pe),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

`ifdef DISPATCH_STATS_EN
   logic [PCK_NUM-1:0] w_head_pck;
   assign w_head_pck = w_data_pe[XY_SIZE +: PCK_NUM];

   // Counts completed blocks leaving the node and cycles the NoC back-pressures a valid flit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_blocks_sent  <= 32'd0;
         o_stall_cycles <= 32'd0;
      end else begin
         if (w_pop && (w_head_pck == LAST_ROW)) begin
            o_blocks_sent <= o_blocks_sent + 32'd1;
         end
         if (w_valid_pe && !w_ready_pe) begin
            o_stall_cycles <= o_stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule
